// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcodes, step encoding and IR field helpers for proc_core
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef logic [1:0] step_t;

  localparam step_t T0 = 2'd0;
  localparam step_t T1 = 2'd1;
  localparam step_t T2 = 2'd2;
  localparam step_t T3 = 2'd3;

  // IR is zero-extended to 32 bits so one helper serves every register count
  function automatic logic [2:0] ir_op(input logic [31:0] ir, input int rw);
    return 3'(ir >> (2 * rw));
  endfunction

  function automatic logic [7:0] ir_rx(input logic [31:0] ir, input int rw);
    return 8'((ir >> rw) & ((32'd1 << rw) - 32'd1));
  endfunction

  function automatic logic [7:0] ir_ry(input logic [31:0] ir, input int rw);
    return 8'(ir & ((32'd1 << rw) - 32'd1));
  endfunction

endpackage

// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - step sequencing and instruction decode for proc_core
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int NREG = 8,
  localparam int RW = $clog2(NREG),
  localparam int IR_W = 3 + 2 * RW
) (
  input  logic [IR_W-1:0] ir,
  input  step_t           step,
  input  logic            run,
  input  logic            zero,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            din_out,
  output logic            g_out,
  output logic            ain,
  output logic            gin,
  output logic [2:0]      alu_op,
  output logic            ir_en,
  output logic            done,
  output step_t           step_next
);

  logic [31:0]   ir32;
  logic [2:0]    op;
  logic [RW-1:0] rx;
  logic [RW-1:0] ry;

  assign ir32   = 32'(ir);
  assign op     = ir_op(ir32, RW);
  assign rx     = RW'(ir_rx(ir32, RW));
  assign ry     = RW'(ir_ry(ir32, RW));
  assign alu_op = op;

  always_comb begin
    rin       = '0;
    rout      = '0;
    din_out   = 1'b0;
    g_out     = 1'b0;
    ain       = 1'b0;
    gin       = 1'b0;
    ir_en     = 1'b0;
    done      = 1'b0;
    step_next = step;
    case (step)
      T0: begin
        ir_en = run;
        if (run) step_next = T1;
      end
      T1: begin
        case (op)
          OP_MV: begin
            rout[ry]  = 1'b1;
            rin[rx]   = 1'b1;
            done      = 1'b1;
            step_next = T0;
          end
          OP_MVI: begin
            din_out   = 1'b1;
            rin[rx]   = 1'b1;
            done      = 1'b1;
            step_next = T0;
          end
          OP_MVNZ: begin
            // Bus still carries Ry so the step looks the same whether or not it writes
            rout[ry]  = 1'b1;
            rin[rx]   = ~zero;
            done      = 1'b1;
            step_next = T0;
          end
          OP_NOP: begin
            done      = 1'b1;
            step_next = T0;
          end
          default: begin
            rout[rx]  = 1'b1;
            ain       = 1'b1;
            step_next = T2;
          end
        endcase
      end
      T2: begin
        rout[ry]  = 1'b1;
        gin       = 1'b1;
        step_next = T3;
      end
      default: begin
        g_out     = 1'b1;
        rin[rx]   = 1'b1;
        done      = 1'b1;
        step_next = T0;
      end
    endcase
  end

endmodule

// File: rtl/proc_core.sv
// rtl/proc_core.sv - multi-cycle bus processor: register file, A/G, ALU and bus mux
module proc_core
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Run,
  output logic [DATA_W-1:0] Bus,
  output logic              Done,
  output logic              Zero
);

  localparam int RW   = $clog2(NREG);
  localparam int IR_W = 3 + 2 * RW;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] alu_res;
  logic [IR_W-1:0]   ir_q;
  step_t             step_q;
  step_t             step_next;
  logic              zero_q;
  logic [NREG-1:0]   rin;
  logic [NREG-1:0]   rout;
  logic              din_out;
  logic              g_out;
  logic              ain;
  logic              gin;
  logic              ir_en;
  logic [2:0]        alu_op;

  proc_ctrl #(.NREG(NREG)) u_ctrl (
    .ir        (ir_q),
    .step      (step_q),
    .run       (Run),
    .zero      (zero_q),
    .rin       (rin),
    .rout      (rout),
    .din_out   (din_out),
    .g_out     (g_out),
    .ain       (ain),
    .gin       (gin),
    .alu_op    (alu_op),
    .ir_en     (ir_en),
    .done      (Done),
    .step_next (step_next)
  );

  // Selects are one-hot (or all clear), so OR-ing the gated sources is a plain mux
  always_comb begin
    Bus = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rout[i]) Bus = Bus | regs[i];
    end
    if (din_out) Bus = Bus | DIN;
    if (g_out)   Bus = Bus | g_q;
  end

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_res = a_q + Bus;
      OP_SUB:  alu_res = a_q - Bus;
      OP_AND:  alu_res = a_q & Bus;
      OP_OR:   alu_res = a_q | Bus;
      default: alu_res = a_q;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      step_q <= T0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      zero_q <= 1'b1;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      step_q <= step_next;
      if (ir_en) ir_q <= DIN[IR_W-1:0];
      if (ain)   a_q  <= Bus;
      if (gin) begin
        g_q    <= alu_res;
        zero_q <= (alu_res == '0);
      end
      for (int i = 0; i < NREG; i++) begin
        if (rin[i]) regs[i] <= Bus;
      end
    end
  end

  assign Zero = zero_q;

endmodule
